// File: rtl/booth_mul_pkg.sv
// ============================================================================
// Module      : booth_mul_pkg
// Description : Shared types and constants for the sequential Booth multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_mul_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Encodings of the {Q[0], q_m1} pair that modify the accumulator
  localparam logic [1:0] BOOTH_SUB = 2'b10;
  localparam logic [1:0] BOOTH_ADD = 2'b01;

  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_mul_step.sv
// ============================================================================
// Module      : booth_mul_step
// Description : One combinational radix-2 Booth step: add/sub, then arithmetic
//               right shift of {A, Q, q_m1}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mul_step
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] a,
  input  logic [WIDTH:0]   q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH+1:0] a_nxt,
  output logic [WIDTH:0]   q_nxt,
  output logic             q_m1_nxt
);

  logic [WIDTH+1:0] w_m_ext;
  logic [WIDTH+1:0] w_sum;

  assign w_m_ext = {m[WIDTH], m};

  always_comb begin
    w_sum = a;
    case ({q[0], q_m1})
      BOOTH_SUB: w_sum = a - w_m_ext;
      BOOTH_ADD: w_sum = a + w_m_ext;
      default:   w_sum = a;
    endcase
  end

  assign a_nxt    = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
  assign q_nxt    = {w_sum[0], q[WIDTH:1]};
  assign q_m1_nxt = q[0];

endmodule

`default_nettype wire

// File: rtl/booth_mul_seq.sv
// ============================================================================
// Module      : booth_mul_seq
// Description : Sequential radix-2 Booth multiplier, signed/unsigned per
//               operation, one step per clock. Optional BOOTH_MUL_ZERO_SKIP_EN
//               completes zero-operand multiplies on the accept edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mul_seq
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sign_mode,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] z
);

  localparam int              c_CW   = count_width(WIDTH);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH);

  state_t             r_state;
  logic [WIDTH+1:0]   r_a;
  logic [WIDTH:0]     r_q;
  logic [WIDTH:0]     r_m;
  logic               r_q_m1;
  logic [c_CW-1:0]    r_count;
  logic [2*WIDTH-1:0] r_z;
  logic               r_valid;

  logic [WIDTH:0]     w_x_ext;
  logic [WIDTH:0]     w_y_ext;
  logic [WIDTH+1:0]   w_a_nxt;
  logic [WIDTH:0]     w_q_nxt;
  logic               w_q_m1_nxt;
  logic [2*WIDTH+2:0] w_prod;
  logic               w_skip;

  assign w_x_ext = {sign_mode & x[WIDTH-1], x};
  assign w_y_ext = {sign_mode & y[WIDTH-1], y};

`ifdef BOOTH_MUL_ZERO_SKIP_EN
  assign w_skip = (x == '0) || (y == '0);
`else
  assign w_skip = 1'b0;
`endif

  booth_mul_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a        (r_a),
    .q        (r_q),
    .q_m1     (r_q_m1),
    .m        (r_m),
    .a_nxt    (w_a_nxt),
    .q_nxt    (w_q_nxt),
    .q_m1_nxt (w_q_m1_nxt)
  );

  // The product fits in the low 2*WIDTH bits of the final {A, Q}
  assign w_prod = {w_a_nxt, w_q_nxt};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_q_m1  <= 1'b0;
      r_count <= '0;
      r_z     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_skip) begin
              r_z     <= '0;
              r_valid <= 1'b1;
            end else begin
              r_m     <= w_y_ext;
              r_q     <= w_x_ext;
              r_q_m1  <= 1'b0;
              r_a     <= '0;
              r_count <= '0;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_a    <= w_a_nxt;
          r_q    <= w_q_nxt;
          r_q_m1 <= w_q_m1_nxt;
          if (r_count == c_LAST) begin
            r_z     <= w_prod[2*WIDTH-1:0];
            r_valid <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = (r_state == RUN);
  assign valid = r_valid;
  assign z     = r_z;

endmodule

`default_nettype wire

// File: tb/tb_booth_mul_seq.sv
// ============================================================================
// Module      : tb_booth_mul_seq
// Description : Directed table-driven bench for booth_mul_seq (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_mul_seq;

  localparam int WIDTH = 8;
`ifdef BOOTH_MUL_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  typedef struct {
    string       name;
    logic        sm;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] z;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sign_mode = 1'b0;
  logic [7:0]  x = '0;
  logic [7:0]  y = '0;
  logic        busy;
  logic        valid;
  logic [15:0] z;

  int n_vec  = 0;
  int n_miss = 0;

  booth_mul_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sign_mode (sign_mode),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .valid     (valid),
    .z         (z)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
    if (ZSKIP && (a == 8'h00 || b == 8'h00)) return 0;
    return 9;
  endfunction

  // Latency counts edges after the accept edge until valid is observed
  task automatic run_op(input string name, input logic sm, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] ez);
    int lat;
    bit busy_seen;
    int el;
    el = exp_lat(a, b);
    @(negedge clk);
    start = 1'b1; sign_mode = sm; x = a; y = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; x = 8'($urandom); y = 8'($urandom); sign_mode = ~sm;
    lat = 0;
    busy_seen = busy;
    while (!valid && lat < 40) begin
      @(negedge clk);
      lat++;
      busy_seen |= busy;
    end
    check({name, "_lat"}, lat, el);
    check({name, "_z"}, z, ez);
    check({name, "_busy"}, busy_seen, (el != 0));
    @(negedge clk);
    check({name, "_pulse"}, valid, 1'b0);
  endtask

  vec_t vecs[10];

  initial begin
    int  lat;
    bit  glitch;
    bit  extra;

    vecs[0] = '{"neg128sq",  1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[1] = '{"ffff_u",    1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{"ffff_s",    1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[3] = '{"m1x1",      1'b1, 8'hFF, 8'h01, 16'hFFFF};
    vecs[4] = '{"3x5",       1'b0, 8'h03, 8'h05, 16'h000F};
    vecs[5] = '{"127xm128",  1'b1, 8'h7F, 8'h80, 16'hC080};
    vecs[6] = '{"128x2_u",   1'b0, 8'h80, 8'h02, 16'h0100};
    vecs[7] = '{"5xm3",      1'b1, 8'h05, 8'hFD, 16'hFFF1};
    vecs[8] = '{"zero_x",    1'b0, 8'h00, 8'h7F, 16'h0000};
    vecs[9] = '{"7fsq",      1'b0, 8'h7F, 8'h7F, 16'h3F01};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_z", z, 16'h0000);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].name, vecs[i].sm, vecs[i].x, vecs[i].y, vecs[i].z);

    // Back-to-back: start held high through the valid cycle
    @(negedge clk);
    start = 1'b1; sign_mode = 1'b1; x = 8'hFF; y = 8'h01;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (!valid && lat < 40) begin @(negedge clk); lat++; end
    check("b2b_lat1", lat, 9);
    check("b2b_z1", z, 16'hFFFF);
    @(posedge clk);
    @(negedge clk);
    check("b2b_reaccept", busy, 1'b1);
    start = 1'b0;
    lat = 0;
    while (!valid && lat < 40) begin @(negedge clk); lat++; end
    check("b2b_lat2", lat, 9);
    check("b2b_z2", z, 16'hFFFF);

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    start = 1'b1; sign_mode = 1'b0; x = 8'h03; y = 8'h05;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    glitch = 1'b0;
    while (!valid && lat < 40) begin
      if (lat == 3) begin start = 1'b1; x = 8'h07; y = 8'h09; end
      if (lat == 4) start = 1'b0;
      @(negedge clk);
      lat++;
      if (!valid && !busy) glitch = 1'b1;
    end
    check("ign_lat", lat, 9);
    check("ign_z", z, 16'h000F);
    check("ign_busy_glitch", glitch, 1'b0);
    extra = 1'b0;
    repeat (12) begin @(negedge clk); extra |= valid | busy; end
    check("ign_no_queue", extra, 1'b0);

    // Reset asserted mid-operation
    @(negedge clk);
    start = 1'b1; sign_mode = 1'b0; x = 8'hFF; y = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_z", z, 16'h0000);
    check("mid_rst_valid", valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    extra = 1'b0;
    repeat (12) begin @(negedge clk); extra |= valid | busy; end
    check("mid_rst_stale", extra, 1'b0);
    run_op("post_rst", 1'b0, 8'h03, 8'h05, 16'h000F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
